// File: rtl/rc4_prga_decrypt.sv
// ---------------------------------------------------------------------------------------------
// rc4_prga_decrypt
//
// Purpose
//   Runs the RC4 pseudo-random generation algorithm over an already key-scheduled 256x8 S
//   memory and XORs each keystream byte with the matching byte of a 32-byte encrypted message.
//   Every decrypted byte goes to a RAM and to an external checker. The checker either accepts
//   the byte (check_finish), so the next byte is processed, or rejects it (key_is_wrong), which
//   parks the engine in a sticky fail state.
//
// Ports
//   clk              in   1  rising-edge clock
//   rst_n            in   1  asynchronous active-low reset
//   i_start          in   1  one-cycle decrypt request, honoured only when idle
//   i_restart        in   1  synchronous return to idle from any state
//   o_s_addr         out  8  S memory address
//   o_s_wrdata       out  8  S memory write data
//   o_s_wren         out  1  S memory write enable
//   i_s_rddata       in   8  S memory read data, one cycle after the address
//   o_rom_addr       out  5  encrypted-message ROM address
//   i_rom_rddata     in   8  ROM read data, one cycle after the address
//   o_ram_addr       out  5  decrypted-message RAM address
//   o_ram_wrdata     out  8  decrypted-message RAM write data
//   o_ram_wren       out  1  decrypted-message RAM write enable
//   o_data_decrypted out  8  last decrypted byte, held until the next byte is written
//   o_check_start    out  1  one-cycle request for the checker to validate o_data_decrypted
//   i_check_finish   in   1  checker accepted the byte
//   i_key_is_wrong   in   1  checker rejected the byte (wins over i_check_finish)
//   o_done           out  1  sticky: all 32 bytes accepted
//   o_fail           out  1  sticky: a byte was rejected
// ---------------------------------------------------------------------------------------------
module rc4_prga_decrypt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_restart,
    output logic [7:0] o_s_addr,
    output logic [7:0] o_s_wrdata,
    output logic       o_s_wren,
    input  logic [7:0] i_s_rddata,
    output logic [4:0] o_rom_addr,
    input  logic [7:0] i_rom_rddata,
    output logic [4:0] o_ram_addr,
    output logic [7:0] o_ram_wrdata,
    output logic       o_ram_wren,
    output logic [7:0] o_data_decrypted,
    output logic       o_check_start,
    input  logic       i_check_finish,
    input  logic       i_key_is_wrong,
    output logic       o_done,
    output logic       o_fail
);

    typedef enum logic [3:0] {
        StIdle,
        StLoadI,
        StReadSi,
        StCaptSi,
        StReadSj,
        StCaptSj,
        StWriteSi,
        StWriteSj,
        StReadF,
        StCaptF,
        StWriteRam,
        StCheck,
        StWaitCheck,
        StDone,
        StFail
    } state_e;

    state_e     r_state;

    // Algorithm state
    logic [7:0] r_i;
    logic [7:0] r_j;
    logic [4:0] r_k;
    logic [7:0] r_si;
    logic [7:0] r_sj;
    logic [7:0] r_f;
    logic [7:0] r_enc;

    // Registered outputs
    logic [7:0] r_s_addr;
    logic [7:0] r_s_wrdata;
    logic       r_s_wren;
    logic [4:0] r_rom_addr;
    logic [4:0] r_ram_addr;
    logic [7:0] r_ram_wrdata;
    logic       r_ram_wren;
    logic [7:0] r_data_decrypted;
    logic       r_check_start;
    logic       r_done;
    logic       r_fail;

    // Combinational helpers; all sums wrap mod 256 by truncation
    logic [7:0] w_i_next;
    logic [7:0] w_j_next;
    logic [7:0] w_f_addr;
    logic [7:0] w_plain;
    logic [7:0] w_plain_reg;

    assign w_i_next    = r_i + 8'd1;
    assign w_j_next    = r_j + i_s_rddata;
    assign w_f_addr    = r_si + r_sj;
    assign w_plain     = i_s_rddata ^ i_rom_rddata;
    assign w_plain_reg = r_f ^ r_enc;

    // Outputs are registered: each transition loads the values the entered state must present,
    // so a memory address is stable for the whole cycle of the state that owns it. Anything not
    // explicitly loaded falls back to zero, which keeps every write enable low outside the
    // writing states and after DONE/FAIL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= StIdle;
            r_i              <= 8'd0;
            r_j              <= 8'd0;
            r_k              <= 5'd0;
            r_si             <= 8'd0;
            r_sj             <= 8'd0;
            r_f              <= 8'd0;
            r_enc            <= 8'd0;
            r_s_addr         <= 8'd0;
            r_s_wrdata       <= 8'd0;
            r_s_wren         <= 1'b0;
            r_rom_addr       <= 5'd0;
            r_ram_addr       <= 5'd0;
            r_ram_wrdata     <= 8'd0;
            r_ram_wren       <= 1'b0;
            r_data_decrypted <= 8'd0;
            r_check_start    <= 1'b0;
            r_done           <= 1'b0;
            r_fail           <= 1'b0;
        end else if (i_restart) begin
            // Same register image as reset, taken synchronously
            r_state          <= StIdle;
            r_i              <= 8'd0;
            r_j              <= 8'd0;
            r_k              <= 5'd0;
            r_si             <= 8'd0;
            r_sj             <= 8'd0;
            r_f              <= 8'd0;
            r_enc            <= 8'd0;
            r_s_addr         <= 8'd0;
            r_s_wrdata       <= 8'd0;
            r_s_wren         <= 1'b0;
            r_rom_addr       <= 5'd0;
            r_ram_addr       <= 5'd0;
            r_ram_wrdata     <= 8'd0;
            r_ram_wren       <= 1'b0;
            r_data_decrypted <= 8'd0;
            r_check_start    <= 1'b0;
            r_done           <= 1'b0;
            r_fail           <= 1'b0;
        end else begin
            // Per-cycle defaults for the memory ports and the check pulse
            r_s_addr      <= 8'd0;
            r_s_wrdata    <= 8'd0;
            r_s_wren      <= 1'b0;
            r_rom_addr    <= 5'd0;
            r_ram_addr    <= 5'd0;
            r_ram_wrdata  <= 8'd0;
            r_ram_wren    <= 1'b0;
            r_check_start <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_i     <= 8'd0;
                        r_j     <= 8'd0;
                        r_k     <= 5'd0;
                        r_done  <= 1'b0;
                        r_fail  <= 1'b0;
                        r_state <= StLoadI;
                    end
                end
                StLoadI: begin
                    r_i      <= w_i_next;
                    r_s_addr <= w_i_next;
                    r_state  <= StReadSi;
                end
                StReadSi: begin
                    r_state <= StCaptSi;
                end
                StCaptSi: begin
                    r_si     <= i_s_rddata;
                    r_j      <= w_j_next;
                    r_s_addr <= w_j_next;
                    r_state  <= StReadSj;
                end
                StReadSj: begin
                    r_state <= StCaptSj;
                end
                StCaptSj: begin
                    // Swap, first half: S[i] <= S[j]
                    r_sj       <= i_s_rddata;
                    r_s_addr   <= r_i;
                    r_s_wrdata <= i_s_rddata;
                    r_s_wren   <= 1'b1;
                    r_state    <= StWriteSi;
                end
                StWriteSi: begin
                    // Swap, second half: S[j] <= old S[i]. When i==j this rewrites the same
                    // value, so S is left unchanged.
                    r_s_addr   <= r_j;
                    r_s_wrdata <= r_si;
                    r_s_wren   <= 1'b1;
                    r_state    <= StWriteSj;
                end
                StWriteSj: begin
                    r_s_addr   <= w_f_addr;
                    r_rom_addr <= r_k;
                    r_state    <= StReadF;
                end
                StReadF: begin
                    r_state <= StCaptF;
                end
                StCaptF: begin
                    r_f          <= i_s_rddata;
                    r_enc        <= i_rom_rddata;
                    r_ram_addr   <= r_k;
                    r_ram_wrdata <= w_plain;
                    r_ram_wren   <= 1'b1;
                    r_state      <= StWriteRam;
                end
                StWriteRam: begin
                    r_data_decrypted <= w_plain_reg;
                    r_check_start    <= 1'b1;
                    r_state          <= StCheck;
                end
                StCheck: begin
                    r_state <= StWaitCheck;
                end
                StWaitCheck: begin
                    if (i_key_is_wrong) begin
                        r_fail  <= 1'b1;
                        r_state <= StFail;
                    end else if (i_check_finish && (r_k == 5'd31)) begin
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else if (i_check_finish) begin
                        r_k     <= r_k + 5'd1;
                        r_state <= StLoadI;
                    end
                end
                StDone: begin
                    r_done <= 1'b1;
                end
                StFail: begin
                    r_fail <= 1'b1;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_s_addr         = r_s_addr;
    assign o_s_wrdata       = r_s_wrdata;
    assign o_s_wren         = r_s_wren;
    assign o_rom_addr       = r_rom_addr;
    assign o_ram_addr       = r_ram_addr;
    assign o_ram_wrdata     = r_ram_wrdata;
    assign o_ram_wren       = r_ram_wren;
    assign o_data_decrypted = r_data_decrypted;
    assign o_check_start    = r_check_start;
    assign o_done           = r_done;
    assign o_fail           = r_fail;

endmodule
